// File: rtl/cpu_header_strip.sv
// cpu_header_strip: removes the header beat from each inbound CPU packet.
// The header's low bits become the tuser of every payload beat in that packet.
// Payload beats go out through a 2-entry skid buffer whose head drives m_axis.
module cpu_header_strip #(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               err_cnt
);

  localparam int KW = C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {HDR_S, BODY_S, DROP_S} state_t;

  // One buffered payload beat. tuser travels with the beat, so a new header
  // can be latched while older beats still wait in the buffer.
  typedef struct packed {
    logic [C_DATA_WIDTH-1:0]  data;
    logic [KW-1:0]            keep;
    logic                     last;
    logic [C_TUSER_WIDTH-1:0] user;
  } beat_t;

  state_t                   state_q, state_d;
  logic [C_TUSER_WIDTH-1:0] user_q, user_d;
  beat_t                    ent0_q, ent0_d;   // head, drives m_axis
  beat_t                    ent1_q, ent1_d;
  logic [1:0]               cnt_q, cnt_d;
  logic                     s_ready_q, s_ready_d;
  logic [31:0]              pkt_cnt_q, pkt_cnt_d;
  logic [31:0]              err_cnt_q, err_cnt_d;

  logic  accept, push, pop, err_inc;
  beat_t in_beat;

  // Next-state, buffer and counter logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    user_d    = user_q;
    ent0_d    = ent0_q;
    ent1_d    = ent1_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    err_inc   = 1'b0;

    accept  = s_axis_tvalid && s_ready_q;
    push    = accept && (state_q == BODY_S);
    pop     = (cnt_q != 2'd0) && m_axis_tready;
    in_beat = '{data: s_axis_tdata, keep: s_axis_tkeep,
                last: s_axis_tlast, user: user_q};

    case (state_q)
      HDR_S: begin
        if (accept) begin
          if (s_axis_tlast) begin
            err_inc = 1'b1;                 // runt: header with no payload
          end else if (&s_axis_tkeep) begin
            user_d  = s_axis_tdata[C_TUSER_WIDTH-1:0];
            state_d = BODY_S;
          end else begin
            err_inc = 1'b1;                 // partial header: drop the packet
            state_d = DROP_S;
          end
        end
      end
      BODY_S:  if (accept && s_axis_tlast) state_d = HDR_S;
      DROP_S:  if (accept && s_axis_tlast) state_d = HDR_S;
      default: state_d = HDR_S;
    endcase

    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = in_beat;
        else               ent1_d = in_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = in_beat;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_beat;
        end
      end
      default: ;
    endcase

    if (pop && ent0_q.last && (pkt_cnt_q != 32'hFFFF_FFFF))
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    if (err_inc && (err_cnt_q != 32'hFFFF_FFFF))
      err_cnt_d = err_cnt_q + 32'd1;

    // Header/drop beats never enter the buffer, so only BODY_S needs room.
    s_ready_d = (state_d != BODY_S) || (cnt_d < 2'd2);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= HDR_S;
      user_q    <= '0;
      ent0_q    <= '0;
      ent1_q    <= '0;
      cnt_q     <= 2'd0;
      s_ready_q <= 1'b0;
      pkt_cnt_q <= 32'd0;
      err_cnt_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      user_q    <= user_d;
      ent0_q    <= ent0_d;
      ent1_q    <= ent1_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = ent0_q.data;
  assign m_axis_tkeep  = ent0_q.keep;
  assign m_axis_tlast  = ent0_q.last;
  assign m_axis_tuser  = ent0_q.user;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_cpu_header_strip.sv
// Scoreboard bench for cpu_header_strip: stimulus pushes expected payload
// beats, an independent monitor pops and compares on each output handshake.
module tb_cpu_header_strip;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [UW-1:0] m_user;
  logic [KW-1:0] m_keep;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [31:0]   pkt_cnt;
  logic [31:0]   err_cnt;

  cpu_header_strip #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tuser(m_user), .m_axis_tkeep(m_keep),
    .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            mode = 0;       // 0 always ready, 1 toggle, 2 random, 3 long stalls, 4 manual
  int            exp_pkt = 0;
  int            exp_err = 0;
  logic [UW-1:0] cur_user = '0;

  localparam logic [KW-1:0] KEEP_ALL  = '1;
  localparam logic [KW-1:0] KEEP_HALF = 32'h0000_FFFF;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output ready pattern generator.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      2: m_ready = 1'($urandom_range(0, 1));
      3: m_ready = ($urandom_range(0, 7) == 0);
      default: ;
    endcase
  end

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data %0h with nothing expected", m_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tdata", m_data, e.data);
        check("tkeep", DW'(m_keep), DW'(e.keep));
        check("tlast", DW'(m_last), DW'(e.last));
        check("tuser", DW'(m_user), DW'(e.user));
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic expect_out);
    bit ok;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    if (expect_out) sb.push_back('{data: d, keep: k, last: l, user: cur_user});
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: s_tready stayed 0 for data %0h", d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic send_hdr(input logic [UW-1:0] u);
    send_beat({{(DW-UW){1'b0}}, u}, KEEP_ALL, 1'b0, 1'b0);
    cur_user = u;
    exp_pkt++;
  endtask

  task automatic send_body(input int n, input logic expect_out);
    for (int b = 0; b < n; b++) begin
      if (b == n - 1) send_beat(rand_data(), KEEP_HALF, 1'b1, expect_out);
      else            send_beat(rand_data(), KEEP_ALL, 1'b0, expect_out);
    end
  endtask

  // kind 0 good, 1 runt, 2 partial-keep header.
  task automatic send_pkt(input logic [UW-1:0] u, input int nbody, input int kind);
    case (kind)
      1: begin
        send_beat({{(DW-UW){1'b0}}, u}, KEEP_ALL, 1'b1, 1'b0);
        exp_err++;
      end
      2: begin
        send_beat({{(DW-UW){1'b0}}, u}, KEEP_HALF, 1'b0, 1'b0);
        exp_err++;
        send_body(nbody, 1'b0);
      end
      default: begin
        send_hdr(u);
        send_body(nbody, 1'b1);
      end
    endcase
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_drain: %0d beats never appeared", name, sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string name);
    check({name, "_pkt_cnt"}, DW'(pkt_cnt), DW'(exp_pkt));
    check({name, "_err_cnt"}, DW'(err_cnt), DW'(exp_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    exp_pkt = 0;
    exp_err = 0;
    check("rst_m_tvalid", DW'(m_valid), DW'(1'b0));
    check("rst_s_tready", DW'(s_ready), DW'(1'b0));
    check("rst_m_tdata", m_data, '0);
    check_counters("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 3-beat packet, tuser 0xA5, with latency checks.
    mode = 0;
    send_hdr(128'hA5);
    check("hdr_not_forwarded", DW'(m_valid), DW'(1'b0));
    send_beat(rand_data(), KEEP_ALL, 1'b0, 1'b1);
    check("latency_d1", DW'(m_valid), DW'(1'b1));
    send_beat(rand_data(), KEEP_HALF, 1'b1, 1'b1);
    wait_drain("basic");
    check_counters("basic");

    // Runt then a valid 2-beat packet.
    send_pkt(128'hB1, 0, 1);
    send_pkt(128'hB2, 1, 0);
    wait_drain("runt");
    check_counters("runt");

    // Partial-keep header: whole packet dropped, next packet intact.
    send_pkt(128'hC0, 2, 2);
    wait_drain("badkeep");
    check_counters("badkeep");
    send_pkt(128'hC3, 1, 0);
    wait_drain("after_drop");
    check_counters("after_drop");

    // Ready drops only once two beats are buffered.
    mode = 4;
    m_ready = 1'b0;
    send_hdr(128'hD4);
    send_beat(rand_data(), KEEP_ALL, 1'b0, 1'b1);
    check("ready_one_entry", DW'(s_ready), DW'(1'b1));
    send_beat(rand_data(), KEEP_ALL, 1'b0, 1'b1);
    check("ready_two_entries", DW'(s_ready), DW'(1'b0));
    m_ready = 1'b1;
    send_beat(rand_data(), KEEP_HALF, 1'b1, 1'b1);
    wait_drain("full");
    check_counters("full");

    // Next header accepted while the previous packet's last beat is stalled.
    m_ready = 1'b0;
    send_pkt(128'h11, 2, 0);
    send_hdr(128'h22);
    repeat (5) @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_body(1, 1'b1);
    wait_drain("tuser_per_beat");
    check_counters("tuser_per_beat");

    // 100 packets across ready patterns, with occasional malformed headers.
    for (int i = 0; i < 100; i++) begin
      int kind;
      mode = i % 4;
      kind = (i % 10 == 3) ? 1 : (i % 10 == 7) ? 2 : 0;
      send_pkt(UW'(32'h1000 + i), int'($urandom_range(1, 4)), kind);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
    mode = 0;
    wait_drain("random");
    check_counters("random");

    // Reset mid-body: buffered beat lost, next beat is a header.
    mode = 4;
    m_ready = 1'b0;
    send_hdr(128'h55);
    send_beat(rand_data(), KEEP_ALL, 1'b0, 1'b1);
    do_reset();
    mode = 0;
    send_pkt(128'h77, 1, 0);
    wait_drain("post_reset");
    check_counters("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
